game_flow_ctrl: RTL and testbench

// Top-level sequencer for the game-state machine. Turns raw player buttons into

---
 rtl/game_flow_ctrl.sv | 137 +++++++++++++
 tb/tb_game_flow_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/game_flow_ctrl.sv
// Game sequencer: debounced buttons drive MENU/RUN/PAUSE/OVER, round timer and score.
// Button press reaches the state flags DEBOUNCE_CYCLES+4 cycles later; no backpressure, inputs are sampled every cycle.
module game_flow_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 100_000_000,
  parameter int ROUND_SECS      = 60,
  parameter int SCORE_MAX       = 999
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       btn_quit,
  input  logic       food_eaten,
  input  logic       player_dead,
  output logic       gamemenu,
  output logic       gamerun,
  output logic       gamepause,
  output logic       gameover,
  output logic [6:0] time_left,
  output logic [9:0] score,
  output logic       tick
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int PW = $clog2(TICK_DIV + 1);

  localparam logic [3:0] MENU  = 4'b0001;
  localparam logic [3:0] RUN   = 4'b0010;
  localparam logic [3:0] PAUSE = 4'b0100;
  localparam logic [3:0] OVER  = 4'b1000;

  logic [2:0]         btn_raw;
  logic [2:0]         sync1;
  logic [2:0]         sync2;
  logic [2:0]         stable;
  logic [2:0]         stable_q;
  logic [2:0]         btn_p;
  logic [2:0][DW-1:0] db_cnt;
  logic               start_p;
  logic               pause_p;
  logic               quit_p;

  logic [3:0]         state;
  logic [3:0]         state_nxt;
  logic [PW-1:0]      presc;
  logic               timeout;

  assign btn_raw = {btn_quit, btn_pause, btn_start};

  // Counter only runs while a change is pending; any bounce back to the stable level restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      db_cnt   <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYCLES)) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign btn_p   = stable & ~stable_q;
  assign start_p = btn_p[0];
  assign pause_p = btn_p[1];
  assign quit_p  = btn_p[2];

  // One-hot state register doubles as the registered flag outputs.
  assign gamemenu  = state[0];
  assign gamerun   = state[1];
  assign gamepause = state[2];
  assign gameover  = state[3];

  assign tick    = gamerun && (presc == PW'(TICK_DIV - 1));
  assign timeout = tick && (time_left == 7'd1);

  always_comb begin
    state_nxt = state;
    case (state)
      MENU: begin
        if (start_p) state_nxt = RUN;
      end
      RUN: begin
        if (player_dead)  state_nxt = OVER;
        else if (timeout) state_nxt = OVER;
        else if (quit_p)  state_nxt = MENU;
        else if (pause_p) state_nxt = PAUSE;
      end
      PAUSE: begin
        if (quit_p)                  state_nxt = MENU;
        else if (pause_p || start_p) state_nxt = RUN;
      end
      OVER: begin
        if (quit_p || start_p) state_nxt = MENU;
      end
      default: state_nxt = MENU;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= MENU;
      score     <= '0;
      time_left <= 7'(ROUND_SECS);
      presc     <= '0;
    end else begin
      state <= state_nxt;
      if (gamemenu && start_p) begin
        score     <= '0;
        time_left <= 7'(ROUND_SECS);
        presc     <= '0;
      end else if (gamerun) begin
        if (food_eaten && (score < 10'(SCORE_MAX))) score <= score + 10'd1;
        if (tick) begin
          presc <= '0;
          if (time_left != 7'd0) time_left <= time_left - 7'd1;
        end else begin
          presc <= presc + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus a randomized run against a
// cycle-level reference model built from the game rules.
module tb_game_flow_ctrl;

  localparam int DEB   = 4;
  localparam int TDIV  = 10;
  localparam int ROUND = 3;
  localparam int SMAX  = 5;

  localparam int M_MENU  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_OVER  = 3;

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       reset = 1'b1;
  logic       btn_start = 1'b0;
  logic       btn_pause = 1'b0;
  logic       btn_quit = 1'b0;
  logic       food_eaten = 1'b0;
  logic       player_dead = 1'b0;
  logic       gamemenu, gamerun, gamepause, gameover, tick;
  logic [6:0] time_left;
  logic [9:0] score;

  int checks = 0;
  int passed = 0;

  always #5 if (clk_en) clk = ~clk;

  game_flow_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .TICK_DIV(TDIV),
    .ROUND_SECS(ROUND),
    .SCORE_MAX(SMAX)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_start(btn_start),
    .btn_pause(btn_pause),
    .btn_quit(btn_quit),
    .food_eaten(food_eaten),
    .player_dead(player_dead),
    .gamemenu(gamemenu),
    .gamerun(gamerun),
    .gamepause(gamepause),
    .gameover(gameover),
    .time_left(time_left),
    .score(score),
    .tick(tick)
  );

  // Reference model: a button level registers once the synchronised input has
  // disagreed with it for DEB+1 consecutive samples; a press pulses for one cycle.
  int       m_state, m_score, m_tl, m_presc;
  bit [7:0] m_hist [3];
  bit       m_stab [3];
  bit       m_prev [3];

  always @(posedge clk or negedge reset) begin
    bit raw [3];
    bit p [3];
    bit flip;
    bit tick_now;
    int old_tl;
    if (!reset) begin
      for (int b = 0; b < 3; b++) begin
        m_hist[b] = '0;
        m_stab[b] = 1'b0;
        m_prev[b] = 1'b0;
      end
      m_state = M_MENU;
      m_score = 0;
      m_tl    = ROUND;
      m_presc = 0;
    end else begin
      raw[0] = btn_start;
      raw[1] = btn_pause;
      raw[2] = btn_quit;
      for (int b = 0; b < 3; b++) begin
        p[b] = m_stab[b] && !m_prev[b];
        flip = 1'b1;
        for (int j = 1; j <= DEB + 1; j++)
          if (m_hist[b][j] == m_stab[b]) flip = 1'b0;
        m_prev[b] = m_stab[b];
        if (flip) m_stab[b] = !m_stab[b];
        m_hist[b] = {m_hist[b][6:0], raw[b]};
      end
      case (m_state)
        M_MENU: if (p[0]) begin
          m_state = M_RUN;
          m_score = 0;
          m_tl    = ROUND;
          m_presc = 0;
        end
        M_RUN: begin
          if (food_eaten && m_score < SMAX) m_score = m_score + 1;
          tick_now = (m_presc == TDIV - 1);
          old_tl   = m_tl;
          if (tick_now) begin
            m_presc = 0;
            if (m_tl > 0) m_tl = m_tl - 1;
          end else begin
            m_presc = m_presc + 1;
          end
          if (player_dead)                   m_state = M_OVER;
          else if (tick_now && old_tl == 1)  m_state = M_OVER;
          else if (p[2])                     m_state = M_MENU;
          else if (p[1])                     m_state = M_PAUSE;
        end
        M_PAUSE: begin
          if (p[2])             m_state = M_MENU;
          else if (p[1] || p[0]) m_state = M_RUN;
        end
        default: if (p[2] || p[0]) m_state = M_MENU;
      endcase
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    btn_start = 1'b0; btn_pause = 1'b0; btn_quit = 1'b0;
    food_eaten = 1'b0; player_dead = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic start_run();
    int n = 0;
    do_reset();
    btn_start = 1'b1;
    while (gamerun !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    btn_start = 1'b0;
    checks++;
    if (gamerun !== 1'b1) $display("FAIL start_run: gamerun=%b after %0d cycles, required 1", gamerun, n);
    else passed++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3 reset = 1'b0;
    #3;
    checks++;
    if ({gameover, gamepause, gamerun, gamemenu} !== 4'b0001)
      $display("FAIL reset_flags: got %b, required 0001", {gameover, gamepause, gamerun, gamemenu});
    else passed++;
    checks++;
    if (score !== 10'd0) $display("FAIL reset_score: got %0d, required 0", score); else passed++;
    checks++;
    if (time_left !== 7'(ROUND)) $display("FAIL reset_time_left: got %0d, required %0d", time_left, ROUND); else passed++;
    checks++;
    if (tick !== 1'b0) $display("FAIL reset_tick: got %b, required 0", tick); else passed++;
    #3 reset = 1'b1;
    #3 clk_en = 1'b1;
  endtask

  task automatic test_bounce();
    @(negedge clk);
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    btn_start = 1'b0;
    repeat (3) @(negedge clk);
    btn_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (gamerun !== (k >= DEB + 4))
        $display("FAIL bounce_run k=%0d: gamerun=%b, required %b", k, gamerun, (k >= DEB + 4));
      else passed++;
    end
    btn_start = 1'b0;
  endtask

  task automatic test_run();
    int ticks = 0, last = -1, over_at = -1;
    start_run();
    for (int i = 0; i < 40; i++) begin
      food_eaten = (i < 7);
      @(negedge clk);
      if (i == 3) begin
        checks++;
        if (score !== 10'd4) $display("FAIL run_score4: got %0d, required 4", score); else passed++;
      end
      if (i == 6) begin
        checks++;
        if (score !== 10'(SMAX)) $display("FAIL run_score_sat: got %0d, required %0d", score, SMAX); else passed++;
      end
      if (tick === 1'b1) begin
        ticks++;
        checks++;
        if (time_left !== 7'(ROUND - ticks + 1))
          $display("FAIL run_tick_tl #%0d: time_left=%0d, required %0d", ticks, time_left, ROUND - ticks + 1);
        else passed++;
        if (last >= 0) begin
          checks++;
          if (i - last != TDIV) $display("FAIL run_tick_gap: got %0d, required %0d", i - last, TDIV); else passed++;
        end
        last = i;
      end
      if (gameover === 1'b1 && over_at < 0) over_at = i;
    end
    food_eaten = 1'b0;
    checks++;
    if (ticks != ROUND) $display("FAIL run_tick_count: got %0d, required %0d", ticks, ROUND); else passed++;
    checks++;
    if (over_at != last + 1) $display("FAIL run_over_edge: over at %0d, required %0d", over_at, last + 1); else passed++;
    checks++;
    if (time_left !== 7'd0 || score !== 10'(SMAX) || gameover !== 1'b1)
      $display("FAIL run_final: tl=%0d score=%0d over=%b, required 0 %0d 1", time_left, score, gameover, SMAX);
    else passed++;
  endtask

  // RUN cycle k (1-based, paused cycles excluded) ticks iff k is a multiple of TDIV.
  task automatic test_pause();
    int k = 1, pcyc = 0, i = 0;
    start_run();
    while (k < 25 && i < 150) begin
      btn_pause  = ((i >= 4 && i < 14) || (i >= 70 && i < 80));
      food_eaten = (i == 40);
      @(negedge clk);
      i++;
      if (gamerun === 1'b1) begin
        k++;
        checks++;
        if (tick !== (k % TDIV == 0) || time_left !== 7'(ROUND - (k - 1) / TDIV))
          $display("FAIL pause_run k=%0d: tick=%b tl=%0d, required %b %0d", k, tick, time_left, (k % TDIV == 0), ROUND - (k - 1) / TDIV);
        else passed++;
      end else if (gamepause === 1'b1) begin
        pcyc++;
        checks++;
        if (tick !== 1'b0 || time_left !== 7'(ROUND - k / TDIV) || score !== 10'd0)
          $display("FAIL pause_frozen: tick=%b tl=%0d score=%0d, required 0 %0d 0", tick, time_left, score, ROUND - k / TDIV);
        else passed++;
      end else begin
        checks++;
        $display("FAIL pause_state: flags=%b, required RUN or PAUSE", {gameover, gamepause, gamerun, gamemenu});
      end
    end
    btn_pause = 1'b0;
    food_eaten = 1'b0;
    checks++;
    if (pcyc < 50 || k != 25) $display("FAIL pause_span: pause cycles=%0d run cycles=%0d, required >=50 and 25", pcyc, k);
    else passed++;
  endtask

  task automatic test_priority();
    start_run();
    btn_quit = 1'b1;
    repeat (DEB + 3) @(negedge clk);
    player_dead = 1'b1;
    food_eaten  = 1'b1;
    @(negedge clk);
    player_dead = 1'b0;
    food_eaten  = 1'b0;
    btn_quit    = 1'b0;
    checks++;
    if ({gameover, gamepause, gamerun, gamemenu} !== 4'b1000 || score !== 10'd1)
      $display("FAIL prio_dead_quit: flags=%b score=%0d, required 1000 1", {gameover, gamepause, gamerun, gamemenu}, score);
    else passed++;
    food_eaten = 1'b1;
    @(negedge clk);
    food_eaten = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (score !== 10'd1 || time_left !== 7'(ROUND))
      $display("FAIL over_hold: score=%0d tl=%0d, required 1 %0d", score, time_left, ROUND);
    else passed++;
    btn_start = 1'b1;
    repeat (DEB + 3) @(negedge clk);
    checks++;
    if (gameover !== 1'b1) $display("FAIL over_wait: gameover=%b, required 1", gameover); else passed++;
    @(negedge clk);
    checks++;
    if (gamemenu !== 1'b1) $display("FAIL over_to_menu: gamemenu=%b, required 1", gamemenu); else passed++;
    repeat (12) @(negedge clk);
    checks++;
    if (gamemenu !== 1'b1) $display("FAIL hold_one_pulse: gamemenu=%b, required 1", gamemenu); else passed++;
    btn_start = 1'b0;

    start_run();
    btn_quit  = 1'b1;
    btn_pause = 1'b1;
    repeat (DEB + 3) @(negedge clk);
    checks++;
    if (gamerun !== 1'b1) $display("FAIL prio_qp_wait: gamerun=%b, required 1", gamerun); else passed++;
    @(negedge clk);
    checks++;
    if ({gameover, gamepause, gamerun, gamemenu} !== 4'b0001)
      $display("FAIL prio_quit_pause: flags=%b, required 0001", {gameover, gamepause, gamerun, gamemenu});
    else passed++;
    btn_quit  = 1'b0;
    btn_pause = 1'b0;
  endtask

  task automatic test_async_reset();
    start_run();
    food_eaten = 1'b1;
    repeat (3) @(negedge clk);
    food_eaten = 1'b0;
    checks++;
    if (score !== 10'd3) $display("FAIL areset_pre_score: got %0d, required 3", score); else passed++;
    repeat (8) @(negedge clk);
    btn_start = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if (gamemenu !== 1'b1 || score !== 10'd0 || time_left !== 7'(ROUND))
      $display("FAIL areset_now: menu=%b score=%0d tl=%0d, required 1 0 %0d", gamemenu, score, time_left, ROUND);
    else passed++;
    @(negedge clk);
    reset = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      checks++;
      if (gamerun !== (k >= DEB + 4))
        $display("FAIL areset_debounce k=%0d: gamerun=%b, required %b", k, gamerun, (k >= DEB + 4));
      else passed++;
    end
    btn_start = 1'b0;
  endtask

  task automatic test_random();
    int   hc [3];
    logic val [3];
    logic [21:0] got, exp;
    do_reset();
    for (int b = 0; b < 3; b++) begin
      hc[b]  = 0;
      val[b] = 1'b0;
    end
    for (int c = 0; c < 800; c++) begin
      for (int b = 0; b < 3; b++) begin
        if (hc[b] == 0) begin
          val[b] = (b == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
          hc[b]  = $urandom_range(1, 14);
        end else begin
          hc[b]--;
        end
      end
      btn_start   = val[0];
      btn_pause   = val[1];
      btn_quit    = val[2];
      food_eaten  = ($urandom_range(0, 3) == 0);
      player_dead = ($urandom_range(0, 59) == 0);
      @(negedge clk);
      got = {gameover, gamepause, gamerun, gamemenu, time_left, score, tick};
      exp = {4'(1 << m_state), 7'(m_tl), 10'(m_score), (m_state == M_RUN && m_presc == TDIV - 1)};
      checks++;
      if (got !== exp) $display("FAIL random c=%0d: got %h, required %h", c, got, exp);
      else passed++;
    end
    btn_start = 1'b0; btn_pause = 1'b0; btn_quit = 1'b0;
    food_eaten = 1'b0; player_dead = 1'b0;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_run();
    test_pause();
    test_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", passed, checks);
    $fatal(1);
  end

endmodule
